// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types, widths and address checking for the data-memory responder
package riscv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the byte address is not word aligned or has any bit set above the word-index field.
    function automatic logic access_err(input logic [63:0] addr, input int unsigned idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 32'd2)) != 64'd0);
    endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// rtl/riscv_dmem_responder_if.sv - request/response bus between the core memory port and the responder
interface riscv_dmem_responder_if import riscv_mem_pkg::*; #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/riscv_mem_array.sv
// rtl/riscv_mem_array.sv - single-port word RAM with byte write enables and registered read
module riscv_mem_array import riscv_mem_pkg::*; #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // One access per enabled cycle: byte-masked write, or a read captured into rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - one-outstanding load/store responder with programmable wait states
module riscv_dmem_responder import riscv_mem_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    riscv_dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [WORD_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic [WORD_W-1:0] rdata_hold;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] rdata_out;
    logic              access;
    logic              cap_err;

    // The array is touched only on the last wait edge, so an aborted request never writes.
    assign access  = (state == WAIT) && (cnt == 4'd0);
    assign cap_err = access_err(64'(cap_addr), IDX_W);

    riscv_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (access && !cap_err),
        .we    (cap_we),
        .be    (cap_be),
        .addr  (cap_addr[IDX_W+1:2]),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

    // Load data comes straight from the array read register; stores and errors answer zero.
    assign rdata_out     = (state == RESP) ? (rsp_load_q ? ram_rdata : '0) : rdata_hold;
    assign bus.rsp_rdata = rdata_out;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    // Request sequencing: capture, count down wait states, emit a one-cycle response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_be      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_we    <= bus.req_we;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        cap_be    <= bus.req_be;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= cap_err;
                        rsp_load_q  <= !cap_we && !cap_err;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_load_q  <= 1'b0;
                    rdata_hold  <= rdata_out;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - scoreboard bench for riscv_dmem_responder
module tb_riscv_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset0 = 1'b0;
    logic reset1 = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    riscv_dmem_responder_if #(.ADDR_W(32)) bus0();
    riscv_dmem_responder_if #(.ADDR_W(32)) bus1();

    riscv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset0), .bus(bus0)
    );
    riscv_dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset1), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (!sel) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d; bus0.req_be = be;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = d; bus1.req_be = be;
        end
    endtask

    // Presents a request and returns the number of the edge that accepts it; the
    // expected response (data, error, cycle of rsp_valid) goes to the scoreboard.
    task automatic issue(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr,
                         input bit chk, output int tacc);
        int n;
        exp_t e;
        @(negedge clk);
        drive(sel, 1'b1, we, a, d, be);
        n = 0;
        while (!(sel ? bus1.req_ready : bus0.req_ready)) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected acceptance");
                tacc = -1;
                return;
            end
        end
        tacc = cyc + 1;
        if (chk) begin
            e.rdata = erd;
            e.err   = eerr;
            e.cyc   = tacc + (sel ? 0 : 2) + 1;
            if (sel) q1.push_back(e); else q0.push_back(e);
        end
    endtask

    task automatic drain(input bit sel);
        int n;
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        while ((sel ? q1.size() : q0.size()) != 0 || (sel ? bus1.busy : bus0.busy)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL drain_timeout: got busy/pending after 100 cycles expected idle");
                return;
            end
        end
    endtask

    // Scoreboard monitors: compare each response pulse against the oldest expectation.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.rsp_valid) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u0_unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                check("u0_rdata", bus0.rsp_rdata, e.rdata);
                check("u0_err", {31'b0, bus0.rsp_err}, {31'b0, e.err});
                check("u0_latency", 32'(cyc), 32'(e.cyc));
            end
        end else if (reset0) begin
            check("u0_err_idle", {31'b0, bus0.rsp_err}, 32'h0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.rsp_valid) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u1_unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                check("u1_rdata", bus1.rsp_rdata, e.rdata);
                check("u1_err", {31'b0, bus1.rsp_err}, {31'b0, e.err});
                check("u1_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish after 200000 time units expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t, t1, t2, t3, nb;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rst_rsp_valid", {31'b0, bus0.rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'b0, bus0.rsp_err}, 32'h0);
        check("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
        check("rst_busy", {31'b0, bus0.busy}, 32'h0);
        check("rst_req_ready", {31'b0, bus0.req_ready}, 32'h1);
        @(negedge clk);
        reset0 = 1'b1;
        reset1 = 1'b1;

        // Basic store then load
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1, t);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1, t);
        drain(0);

        // Byte strobes and empty strobe
        issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1, t);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 1, t);
        issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1, t);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1, t);
        drain(0);

        // Misaligned load, out-of-range store, no aliasing onto word 0
        issue(0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 1, t);
        issue(0, 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, 1, t);
        issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1, t);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1, t);
        drain(0);

        // Reset during WAIT discards the pending store
        issue(0, 1'b1, 32'h20, 32'h01234567, 4'hF, 32'h0, 1'b0, 1, t);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h01234567, 1'b0, 1, t);
        drain(0);
        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, t);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset0 = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'b0, bus0.rsp_valid}, 32'h0);
        check("midrst_rsp_rdata", bus0.rsp_rdata, 32'h0);
        check("midrst_rsp_err", {31'b0, bus0.rsp_err}, 32'h0);
        check("midrst_busy", {31'b0, bus0.busy}, 32'h0);
        @(negedge clk);
        reset0 = 1'b1;
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h01234567, 1'b0, 1, t);
        drain(0);

        // Back-to-back with req_valid held high
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1, t1);
        issue(0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 1, t2);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h01234567, 1'b0, 1, t3);
        drain(0);
        check("b2b_spacing_1", 32'(t2 - t1), 32'd5);
        check("b2b_spacing_2", 32'(t3 - t2), 32'd5);

        // Zero wait-state instance
        issue(1, 1'b1, 32'h4, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 1, t);
        drain(1);
        issue(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 1, t);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        nb = 0;
        while (bus1.busy && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        check("w0_busy_cycles", 32'(nb), 32'd2);
        drain(1);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
